// File: rtl/updown_pkg.sv
// updown_pkg: shared FSM state encoding and step directions for updown_step_ctrl
package updown_pkg;
   typedef enum logic [2:0] {IDLE, HOLD_UP, HOLD_DN, RPT_UP, RPT_DN} updown_state_t;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/repeat_timer.sv
// repeat_timer: loadable down-counter that flags when it has run down to zero
module repeat_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en) cnt <= cnt - 1'b1;
   end
   assign zero = (cnt == '0);
endmodule

// File: rtl/updown_step_ctrl.sv
// updown_step_ctrl: bounded wrapping up/down counter driven by debounced buttons.
// Auto-repeat while held is built only with UPDOWN_STEP_CTRL_AUTOREPEAT_EN defined.
module updown_step_ctrl
   import updown_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int MAX_VAL       = 9,
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_press,
   input  logic             up_held,
   input  logic             dn_press,
   input  logic             dn_held,
   output logic [WIDTH-1:0] count,
   output logic             step,
   output logic             wrap,
   output logic             busy
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_params
      $error("updown_step_ctrl: illegal parameter set");
   end
   updown_state_t    state, nstate;
   logic             st_up, held, expire, go, dir, wrap_n;
   logic [WIDTH-1:0] cnt_n;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
   localparam int TW = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
   logic          t_zero, t_en;
   logic [TW-1:0] t_val;
   assign t_val  = (state == IDLE) ? TW'(HOLD_CYCLES - 1) : TW'(REPEAT_CYCLES - 1);
   assign t_en   = (state != IDLE) & held & ~t_zero;
   assign expire = t_zero;
   repeat_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (go),
      .load_val (t_val),
      .en       (t_en),
      .zero     (t_zero)
   );
`else
   assign expire = 1'b0;
`endif
   always_comb begin
      st_up  = (state == HOLD_UP) || (state == RPT_UP);
      held   = st_up ? up_held : dn_held;
      go     = (state == IDLE) ? (up_press ^ dn_press) : (held & expire);
      dir    = (state == IDLE) ? (up_press ? DIR_UP : DIR_DN) : st_up;
      // release wins over a timer expiring in the same cycle
      nstate = (state == IDLE) ? (go ? (dir == DIR_UP ? HOLD_UP : HOLD_DN) : IDLE)
             : !held ? IDLE
             : go ? (st_up ? RPT_UP : RPT_DN) : state;
      wrap_n = (dir == DIR_UP) ? (count == MAXV) : (count == '0);
      cnt_n  = wrap_n ? ((dir == DIR_UP) ? '0 : MAXV)
                      : ((dir == DIR_UP) ? count + 1'b1 : count - 1'b1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         step  <= 1'b0;
         wrap  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= nstate;
         step  <= go;
         wrap  <= go & wrap_n;
         busy  <= (nstate != IDLE);
         if (go) count <= cnt_n;
      end
   end
endmodule

// File: tb/tb_updown_step_ctrl.sv
// tb_updown_step_ctrl: directed bench with a press/hold timing model checked every cycle
module tb_updown_step_ctrl;
   localparam int W  = 4;
   localparam int MX = 9;
   localparam int H  = 4;
   localparam int R  = 2;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   logic clk = 0, rst = 1;
   logic up_press = 0, up_held = 0, dn_press = 0, dn_held = 0;
   logic [W-1:0] count;
   logic step, wrap, busy;
   int errors = 0, checks = 0;
   bit chk_en = 0;
   always #5 clk = ~clk;

   updown_step_ctrl #(.WIDTH(W), .MAX_VAL(MX), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk      (clk),
      .rst      (rst),
      .up_press (up_press),
      .up_held  (up_held),
      .dn_press (dn_press),
      .dn_held  (dn_held),
      .count    (count),
      .step     (step),
      .wrap     (wrap),
      .busy     (busy)
   );

   // Model: an active press remembers its direction and how many held cycles have passed.
   int m_count = 0, active = 0, k = 0;
   bit m_step = 0, m_wrap = 0, m_busy = 0;
   task automatic m_apply(input bit up);
      m_step = 1;
      if (up) begin
         m_wrap  = (m_count == MX);
         m_count = m_wrap ? 0 : m_count + 1;
      end else begin
         m_wrap  = (m_count == 0);
         m_count = m_wrap ? MX : m_count - 1;
      end
   endtask
   always @(posedge clk) begin
      m_step = 0;
      m_wrap = 0;
      if (rst) begin
         m_count = 0;
         active  = 0;
      end else if (active == 0) begin
         if (up_press != dn_press) begin
            m_apply(up_press);
            active = up_press ? 1 : 2;
            k = 0;
         end
      end else if (!(active == 1 ? up_held : dn_held)) begin
         active = 0;
      end else begin
         k++;
         if (AR && (k == H || (k > H && (k - H) % R == 0))) m_apply(active == 1);
      end
      m_busy = (active != 0);
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("model_count", 32'(count), m_count);
      chk("model_step", 32'(step), 32'(m_step));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
      chk("model_busy", 32'(busy), 32'(m_busy));
   end

   task automatic drive(input logic up_p, input logic up_h, input logic dn_p, input logic dn_h);
      up_press = up_p;
      up_held  = up_h;
      dn_press = dn_p;
      dn_held  = dn_h;
      @(negedge clk);
   endtask

   int n, nw;
   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1;
      chk("rst_count", 32'(count), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 0;
      // single short press
      drive(1, 1, 0, 0);
      chk("t1_step", 32'(step), 1);
      chk("t1_count", 32'(count), 1);
      drive(0, 1, 0, 0);
      chk("t1_busy", 32'(busy), 1);
      drive(0, 0, 0, 0);
      chk("t1_idle", 32'(busy), 0);
      drive(0, 0, 0, 0);
      // long hold with auto-repeat
      rst = 1;
      drive(0, 0, 0, 0);
      rst = 0;
      n = 0;
      drive(1, 1, 0, 0);
      n += int'(step);
      for (int i = 1; i <= 10; i++) begin
         drive(0, 1, 0, 0);
         n += int'(step);
      end
      drive(0, 0, 0, 0);
      n += int'(step);
      chk("t2_steps", n, AR ? 5 : 1);
      chk("t2_count", 32'(count), AR ? 5 : 1);
      chk("t2_busy", 32'(busy), 0);
      // release on the very cycle the hold timer expires
      drive(1, 1, 0, 0);
      repeat (3) drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
      chk("rel_expiry_step", 32'(step), 0);
      chk("rel_expiry_count", 32'(count), AR ? 6 : 2);
      // wrap downwards from 0, then nine ups through the top
      rst = 1;
      drive(0, 0, 0, 0);
      rst = 0;
      drive(0, 0, 1, 1);
      chk("t3_dn_count", 32'(count), 9);
      chk("t3_dn_step", 32'(step), 1);
      chk("t3_dn_wrap", 32'(wrap), 1);
      drive(0, 0, 0, 0);
      nw = 0;
      for (int i = 0; i < 9; i++) begin
         drive(1, 1, 0, 0);
         nw += int'(wrap);
         drive(0, 0, 0, 0);
      end
      chk("t3_count", 32'(count), 8);
      chk("t3_wraps", nw, 1);
      // simultaneous presses, then opposite button during a hold
      drive(1, 1, 1, 1);
      chk("t4_both_step", 32'(step), 0);
      chk("t4_both_count", 32'(count), 8);
      chk("t4_both_busy", 32'(busy), 0);
      drive(0, 0, 0, 0);
      drive(1, 1, 0, 0);
      drive(0, 1, 1, 1);
      chk("t4_ign_count", 32'(count), 9);
      chk("t4_ign_busy", 32'(busy), 1);
      drive(0, 1, 0, 1);
      drive(0, 0, 0, 0);
      chk("t4_end_count", 32'(count), 9);
      // reset in the middle of repeating
      rst = 1;
      drive(0, 0, 0, 0);
      rst = 0;
      drive(1, 1, 0, 0);
      repeat (6) drive(0, 1, 0, 0);
      chk("t5_pre_count", 32'(count), AR ? 3 : 1);
      rst = 1;
      drive(0, 1, 0, 0);
      chk("t5_count", 32'(count), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_step", 32'(step), 0);
      rst = 0;
      drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
      // 20-cycle hold
      drive(1, 1, 0, 0);
      repeat (19) drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
      chk("t6_count", 32'(count), AR ? 9 : 1);
      drive(0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
